instr_fetch_unit: RTL and testbench

//   Multi-cycle CPU fetch stage: holds PC, fetches one instruction per fetch_en over a
//   req/ack memory handshake with variable latency, and latches it in the instruction register (IR).

---
 rtl/instr_fetch_unit.sv | 129 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Multi-cycle fetch stage: PC register, req/ack instruction fetch into IR,
// decode field split and tracking of the fetched instruction's address.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    input  logic        pc_wr,
    input  logic [31:0] pc_in,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        ir_valid,
    output logic        busy,
    output logic [31:0] pc,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [25:0] jidx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] instr_pc_reg;
    logic [31:0] ir_reg;
    logic [31:0] mem_addr_reg;
    logic [31:0] redirect_reg;
    logic        redirect_valid_reg;
    logic        mem_req_reg;
    logic        busy_reg;
    logic        ir_valid_reg;
    logic [31:0] pc_in_aligned;

    assign pc_in_aligned = pc_in & ~32'd3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg          <= IDLE;
            pc_reg             <= RESET_PC;
            instr_pc_reg       <= RESET_PC;
            ir_reg             <= 32'd0;
            mem_addr_reg       <= RESET_PC;
            redirect_reg       <= 32'd0;
            redirect_valid_reg <= 1'b0;
            mem_req_reg        <= 1'b0;
            busy_reg           <= 1'b0;
            ir_valid_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, HOLD: begin
                    if (fetch_en) begin
                        // A same-cycle redirect bypasses the PC register straight onto the bus.
                        state_reg          <= WAIT;
                        mem_addr_reg       <= pc_wr ? pc_in_aligned : pc_reg;
                        mem_req_reg        <= 1'b1;
                        busy_reg           <= 1'b1;
                        ir_valid_reg       <= 1'b0;
                        redirect_valid_reg <= 1'b0;
                    end else if (pc_wr) begin
                        pc_reg <= pc_in_aligned;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        state_reg          <= HOLD;
                        ir_reg             <= mem_rdata;
                        instr_pc_reg       <= mem_addr_reg;
                        mem_req_reg        <= 1'b0;
                        busy_reg           <= 1'b0;
                        ir_valid_reg       <= 1'b1;
                        redirect_valid_reg <= 1'b0;
                        if (pc_wr) begin
                            pc_reg <= pc_in_aligned;
                        end else if (redirect_valid_reg) begin
                            pc_reg <= redirect_reg;
                        end else begin
                            pc_reg <= mem_addr_reg + PC_STEP;
                        end
                    end else if (pc_wr) begin
                        // The in-flight fetch completes; the redirect only replaces the next PC.
                        redirect_reg       <= pc_in_aligned;
                        redirect_valid_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    mem_req_reg  <= 1'b0;
                    busy_reg     <= 1'b0;
                    ir_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req  = mem_req_reg;
    assign mem_addr = mem_addr_reg;
    assign busy     = busy_reg;
    assign ir_valid = ir_valid_reg;
    assign pc       = pc_reg;
    assign instr_pc = instr_pc_reg;
    assign pc_plus4 = instr_pc_reg + 32'd4;
    assign instr    = ir_reg;

    assign opcode = ir_reg[31:26];
    assign rs     = ir_reg[25:21];
    assign rt     = ir_reg[20:16];
    assign rd     = ir_reg[15:11];
    assign shamt  = ir_reg[10:6];
    assign funct  = ir_reg[5:0];
    assign imm16  = ir_reg[15:0];
    assign jidx   = ir_reg[25:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized fetches checked
// against a transaction-level model of PC/IR behaviour.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic        pc_wr;
    logic [31:0] pc_in;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        ir_valid;
    logic        busy;
    logic [31:0] pc;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] jidx;

    int checks = 0;
    int failures = 0;

    // Architectural model: next fetch address, fetched word and its address.
    logic [31:0] m_pc;
    logic [31:0] m_instr_pc;
    logic [31:0] m_ir;
    logic        m_valid;

    instr_fetch_unit dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en), .pc_wr(pc_wr), .pc_in(pc_in),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ir_valid(ir_valid), .busy(busy), .pc(pc), .instr_pc(instr_pc), .pc_plus4(pc_plus4),
        .instr(instr), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .funct(funct), .imm16(imm16), .jidx(jidx)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] align(input logic [31:0] a);
        return (a / 4) * 4;
    endfunction

    task automatic model_reset;
        m_pc = RST_PC;
        m_instr_pc = RST_PC;
        m_ir = 32'd0;
        m_valid = 1'b0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".instr_pc"}, instr_pc, m_instr_pc);
        chk({tag, ".pc_plus4"}, pc_plus4, m_instr_pc + 32'd4);
        chk({tag, ".instr"}, instr, m_ir);
        chk({tag, ".ir_valid"}, {31'd0, ir_valid}, {31'd0, m_valid});
        chk({tag, ".mem_req"}, {31'd0, mem_req}, 32'd0);
        chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
        chk({tag, ".opcode"}, {26'd0, opcode}, m_ir >> 26);
        chk({tag, ".rs"}, {27'd0, rs}, (m_ir >> 21) % 32);
        chk({tag, ".rt"}, {27'd0, rt}, (m_ir >> 16) % 32);
        chk({tag, ".rd"}, {27'd0, rd}, (m_ir >> 11) % 32);
        chk({tag, ".shamt"}, {27'd0, shamt}, (m_ir >> 6) % 32);
        chk({tag, ".funct"}, {26'd0, funct}, m_ir % 64);
        chk({tag, ".imm16"}, {16'd0, imm16}, m_ir % 65536);
        chk({tag, ".jidx"}, {6'd0, jidx}, m_ir % (1 << 26));
    endtask

    // One fetch: optional same-cycle bypass, ack after lat WAIT cycles, redirects in
    // WAIT cycles selected by redir_mask (bit c-1 = WAIT cycle c; last one wins).
    task automatic do_fetch(input string tag, input bit byp, input logic [31:0] byp_pc,
                            input int lat, input logic [31:0] data,
                            input logic [7:0] redir_mask, input logic [31:0] redir_pc,
                            input bit rnd);
        logic [31:0] addr;
        logic [31:0] last_redir;
        bit          have_redir;
        addr = byp ? align(byp_pc) : m_pc;
        have_redir = 1'b0;
        last_redir = 32'd0;
        fetch_en = 1'b1;
        pc_wr = byp;
        pc_in = byp_pc;
        tick();
        fetch_en = 1'b0;
        pc_wr = 1'b0;
        chk({tag, ".wait_req"}, {31'd0, mem_req}, 32'd1);
        chk({tag, ".wait_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, ".wait_irv"}, {31'd0, ir_valid}, 32'd0);
        chk({tag, ".mem_addr"}, mem_addr, addr);
        for (int c = 1; c <= lat; c++) begin
            mem_ack = (c == lat);
            mem_rdata = (c == lat) ? data : $urandom;
            fetch_en = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            if (redir_mask[c-1]) begin
                pc_wr = 1'b1;
                pc_in = rnd ? $urandom : redir_pc;
                have_redir = 1'b1;
                last_redir = align(pc_in);
            end
            tick();
            mem_ack = 1'b0;
            pc_wr = 1'b0;
            fetch_en = 1'b0;
            mem_rdata = $urandom;
            if (c < lat) begin
                chk({tag, ".hold_req"}, {31'd0, mem_req}, 32'd1);
                chk({tag, ".hold_addr"}, mem_addr, addr);
            end
        end
        m_ir = data;
        m_instr_pc = addr;
        m_pc = have_redir ? last_redir : addr + 32'd4;
        m_valid = 1'b1;
        check_state(tag);
    endtask

    initial begin
        reset = 1'b1;
        fetch_en = 1'b0;
        pc_wr = 1'b0;
        pc_in = 32'd0;
        mem_ack = 1'b0;
        mem_rdata = 32'd0;
        model_reset();
        tick();
        tick();
        check_state("reset_active");
        reset = 1'b0;
        tick();
        check_state("reset_released");

        // Three-cycle latency fetch of addi $t0,$zero,-1.
        do_fetch("fetch_lat3", 1'b0, 32'd0, 3, 32'h2008_FFFF, 8'h00, 32'd0, 1'b0);
        chk("fetch_lat3.opcode_const", {26'd0, opcode}, 32'h08);
        chk("fetch_lat3.imm_const", {16'd0, imm16}, 32'hFFFF);
        chk("fetch_lat3.pc_const", pc, 32'h3004);

        // Redirect during WAIT replaces the +4 next PC.
        do_fetch("redir_wait", 1'b0, 32'd0, 2, 32'h0000_0000, 8'h01, 32'h0000_3100, 1'b0);
        chk("redir_wait.pc_const", pc, 32'h3100);
        do_fetch("after_redir", 1'b0, 32'd0, 1, 32'h8C22_0010, 8'h00, 32'd0, 1'b0);
        chk("after_redir.ipc_const", instr_pc, 32'h3100);

        // Bypass redirect with fetch_en in HOLD; low bits of pc_in dropped.
        do_fetch("bypass", 1'b1, 32'h0000_3203, 2, 32'h0123_4567, 8'h00, 32'd0, 1'b0);
        chk("bypass.ipc_const", instr_pc, 32'h3200);
        chk("bypass.pc_const", pc, 32'h3204);

        // Redirect in ack cycle and two redirects (last wins).
        do_fetch("redir_coinc", 1'b0, 32'd0, 3, 32'hDEAD_BEEF, 8'h04, 32'h0000_5557, 1'b0);
        do_fetch("redir_multi", 1'b0, 32'd0, 4, 32'hCAFE_F00D, 8'h03, 32'h0000_6000, 1'b0);

        // pc_wr alone in HOLD, and an ack outside WAIT, are both absorbed correctly.
        pc_wr = 1'b1;
        pc_in = 32'h0000_4007;
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFF_0000;
        tick();
        pc_wr = 1'b0;
        mem_ack = 1'b0;
        m_pc = 32'h0000_4004;
        check_state("hold_pcwr");

        // Reset mid-WAIT: request drops at once, later ack is ignored.
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        chk("rst_wait.req_before", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_wait.req_async", {31'd0, mem_req}, 32'd0);
        model_reset();
        tick();
        reset = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'h1234_5678;
        tick();
        mem_ack = 1'b0;
        check_state("rst_wait.late_ack");

        // Wrap-around at the top of the address space.
        pc_wr = 1'b1;
        pc_in = 32'hFFFF_FFFC;
        tick();
        pc_wr = 1'b0;
        m_pc = 32'hFFFF_FFFC;
        do_fetch("wrap", 1'b0, 32'd0, 1, 32'h0800_0001, 8'h00, 32'd0, 1'b0);
        chk("wrap.pc_const", pc, 32'h0);
        chk("wrap.pcp4_const", pc_plus4, 32'h0);

        // Back-to-back single-cycle fetches: one instruction per two cycles.
        for (int i = 0; i < 4; i++)
            do_fetch("b2b", 1'b0, 32'd0, 1, $urandom, 8'h00, 32'd0, 1'b0);

        // Randomized fetches with random bypass, latency, redirects and stray fetch_en.
        for (int i = 0; i < 30; i++) begin
            int lat;
            lat = $urandom_range(1, 5);
            if ($urandom_range(0, 3) == 0) begin
                pc_wr = 1'b1;
                pc_in = $urandom;
                tick();
                pc_wr = 1'b0;
                m_pc = align(pc_in);
                check_state("rand_pcwr");
            end
            do_fetch("rand", 1'($urandom_range(0, 1)), $urandom, lat, $urandom,
                     8'($urandom_range(0, 31) & ((1 << lat) - 1)), 32'd0, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
